// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store funct3 encodings, control-bit indices and MEM-stage FSM states
package riscv_pkg;
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;
   localparam int CTL_REG_WE = 0;
   localparam int CTL_MEM_WE = 1;
   localparam int CTL_WB_MEM = 2;
   localparam int CTL_MEM_RE = 3;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} mem_state_e;
endpackage

// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: data-memory valid/ready port
//   request : dmem_req_valid/ready, dmem_we, dmem_addr, dmem_wdata, dmem_be
//   response: dmem_rsp_valid, dmem_rsp_data
//   master = pipeline stage, slave = memory
interface memory_access_stage_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   modport master (
      output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
   );
   modport slave (
      input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment for loads/stores
//   addr[1:0], funct3, data -> be (store byte enables), wdata (lane-replicated store data),
//   rdata (extended load data, from data as the loaded word), misaligned (alignment/funct3 fault)
module lsu_align
   import riscv_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   input  logic [31:0] data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misaligned
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b          = data[{addr, 3'b000} +: 8];
      h          = addr[1] ? data[31:16] : data[15:0];
      misaligned = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
                   (funct3[1:0] == F3_LH[1:0] && addr[0]) ||
                   (funct3[1:0] == F3_LW[1:0] && addr != 2'b00);
      be         = (funct3[1:0] == F3_SB[1:0]) ? 4'b0001 << addr :
                   (funct3[1:0] == F3_SH[1:0]) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata      = (funct3[1:0] == F3_SB[1:0]) ? {4{data[7:0]}} :
                   (funct3[1:0] == F3_SH[1:0]) ? {2{data[15:0]}} : data;
      rdata      = (funct3 == F3_LB)  ? {{24{b[7]}}, b} :
                   (funct3 == F3_LBU) ? {24'h0, b} :
                   (funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                   (funct3 == F3_LHU) ? {16'h0, h} : data;
   end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: RISC-V MEM stage between EX/MEM and MEM/WB registers
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : EX/MEM handshake; alu_out, store_data, funct3, rd, control_unit_signal
//   dmem                    : data-memory request/response port (master)
//   o_valid ... o_bus_error : MEM/WB outputs; o_valid pulses once per retired instruction
module memory_access_stage
   import riscv_pkg::*;
#(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   alu_out,
   input  logic [31:0]                   store_data,
   input  logic [2:0]                    funct3,
   input  logic [4:0]                    rd,
   input  logic [7:0]                    control_unit_signal,
   memory_access_stage_if.master         dmem,
   output logic                          o_valid,
   output logic [31:0]                   o_mem_read_data,
   output logic [31:0]                   o_alu_out,
   output logic [4:0]                    o_rd,
   output logic [7:0]                    o_control_unit_signal,
   output logic                          o_misaligned,
   output logic                          o_bus_error
);
   mem_state_e  state, state_n;
   logic [31:0] cnt, cnt_n;
   logic [31:0] h_alu, h_sd;
   logic [2:0]  h_f3;
   logic [4:0]  h_rd;
   logic [7:0]  h_ctl, ctl_src;
   logic        idle, mem_op, ret, from_in, mis_f, bus_f, ld_ret;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;
   logic        al_mis;
   assign idle    = state == S_IDLE;
   assign in_ready = idle;
   assign mem_op  = control_unit_signal[CTL_MEM_WE] | control_unit_signal[CTL_MEM_RE];
   assign ctl_src = from_in ? control_unit_signal : h_ctl;
   // In IDLE the aligner checks the incoming instruction; otherwise it serves the held one.
   lsu_align u_align (
      .addr       (idle ? alu_out[1:0] : h_alu[1:0]),
      .funct3     (idle ? funct3 : h_f3),
      .data       (state == S_WAIT_RSP ? dmem.dmem_rsp_data : h_sd),
      .be         (al_be),
      .wdata      (al_wdata),
      .rdata      (al_rdata),
      .misaligned (al_mis)
   );
   assign dmem.dmem_req_valid = state == S_REQ;
   assign dmem.dmem_we        = state == S_REQ && h_ctl[CTL_MEM_WE];
   assign dmem.dmem_addr      = state == S_REQ ? {h_alu[31:2], 2'b00} : 32'h0;
   assign dmem.dmem_wdata     = state == S_REQ ? al_wdata : 32'h0;
   assign dmem.dmem_be        = state == S_REQ ? al_be : 4'h0;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ret     = 1'b0;
      from_in = 1'b0;
      mis_f   = 1'b0;
      bus_f   = 1'b0;
      ld_ret  = 1'b0;
      case (state)
         S_IDLE: if (in_valid) begin
            ret     = !mem_op || al_mis;
            from_in = ret;
            mis_f   = mem_op && al_mis;
            state_n = ret ? S_IDLE : S_REQ;
         end
         S_REQ: if (dmem.dmem_req_ready) begin
            // A store completes at the handshake; a load waits for its response.
            ret     = h_ctl[CTL_MEM_WE];
            state_n = ret ? S_IDLE : S_WAIT_RSP;
            cnt_n   = 32'h0;
         end
         S_WAIT_RSP: begin
            cnt_n = cnt + 32'd1;
            if (dmem.dmem_rsp_valid) begin
               ret     = 1'b1;
               ld_ret  = 1'b1;
               state_n = S_IDLE;
            end else if (RSP_TIMEOUT != 0 && cnt_n == RSP_TIMEOUT) begin
               ret     = 1'b1;
               bus_f   = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= S_IDLE;
         cnt                   <= 32'h0;
         h_alu                 <= 32'h0;
         h_sd                  <= 32'h0;
         h_f3                  <= 3'h0;
         h_rd                  <= 5'h0;
         h_ctl                 <= 8'h0;
         o_valid               <= 1'b0;
         o_mem_read_data       <= 32'h0;
         o_alu_out             <= 32'h0;
         o_rd                  <= 5'h0;
         o_control_unit_signal <= 8'h0;
         o_misaligned          <= 1'b0;
         o_bus_error           <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         o_valid <= ret;
         if (idle && in_valid) begin
            h_alu <= alu_out;
            h_sd  <= store_data;
            h_f3  <= funct3;
            h_rd  <= rd;
            h_ctl <= control_unit_signal;
         end
         if (ret) begin
            o_alu_out             <= from_in ? alu_out : h_alu;
            o_rd                  <= from_in ? rd : h_rd;
            // Faulted instructions must not write the register file.
            o_control_unit_signal <= {ctl_src[7:1], ctl_src[CTL_REG_WE] & ~(mis_f | bus_f)};
            o_mem_read_data       <= ld_ret ? al_rdata : 32'h0;
            o_misaligned          <= mis_f;
            o_bus_error           <= bus_f;
         end
      end
   end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed self-checking bench with a retire scoreboard
module tb_memory_access_stage;
   typedef struct {
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [7:0]  ctl;
      logic        mis;
      logic        berr;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] alu_out, store_data;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [7:0]  control_unit_signal;
   logic        o_valid, o_misaligned, o_bus_error;
   logic [31:0] o_mem_read_data, o_alu_out;
   logic [4:0]  o_rd;
   logic [7:0]  o_control_unit_signal;
   int          n_chk = 0, n_fail = 0, n_valid = 0, nv;
   exp_t        q[$];
   exp_t        e;
   memory_access_stage_if bus ();
   memory_access_stage #(.RSP_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .store_data(store_data), .funct3(funct3), .rd(rd),
      .control_unit_signal(control_unit_signal), .dmem(bus),
      .o_valid(o_valid), .o_mem_read_data(o_mem_read_data), .o_alu_out(o_alu_out),
      .o_rd(o_rd), .o_control_unit_signal(o_control_unit_signal),
      .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
   );
   always #5 clk = ~clk;
   function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction
   task automatic push(input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] r,
                       input logic [7:0] ctl, input logic mis, input logic berr);
      exp_t x;
      x.rdata = rdata; x.alu = alu; x.rd = r; x.ctl = ctl; x.mis = mis; x.berr = berr;
      q.push_back(x);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                        input logic [4:0] r, input logic [7:0] ctl);
      alu_out = a; store_data = sd; funct3 = f3; rd = r; control_unit_signal = ctl;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask
   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] rsp, input logic [31:0] exp_d);
      push(exp_d, a, r, 8'h0D, 1'b0, 1'b0);
      issue(a, 32'h0, f3, r, 8'h0D);
      check("ld_req_valid", bus.dmem_req_valid, 1);
      check("ld_addr", bus.dmem_addr, {a[31:2], 2'b00});
      check("ld_we", bus.dmem_we, 0);
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      check("ld_in_ready_wait", in_ready, 0);
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rsp_data  = rsp;
      step();
      bus.dmem_rsp_valid = 1'b0;
   endtask
   task automatic do_store(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd, input int stall);
      push(32'h0, a, 5'd0, 8'h02, 1'b0, 1'b0);
      issue(a, sd, f3, 5'd0, 8'h02);
      for (int i = 0; i <= stall; i++) begin
         check("st_req_valid", bus.dmem_req_valid, 1);
         check("st_addr", bus.dmem_addr, {a[31:2], 2'b00});
         check("st_be", bus.dmem_be, exp_be);
         check("st_wdata", bus.dmem_wdata, exp_wd);
         check("st_we", bus.dmem_we, 1);
         check("st_in_ready", in_ready, 0);
         if (i == stall) bus.dmem_req_ready = 1'b1;
         step();
      end
      bus.dmem_req_ready = 1'b0;
   endtask
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         n_valid++;
         if (q.size() == 0) check("spurious_o_valid", 64'(q.size()), 1);
         else begin
            e = q.pop_front();
            check("o_mem_read_data", o_mem_read_data, e.rdata);
            check("o_alu_out", o_alu_out, e.alu);
            check("o_rd", o_rd, e.rd);
            check("o_ctl", o_control_unit_signal, e.ctl);
            check("o_misaligned", o_misaligned, e.mis);
            check("o_bus_error", o_bus_error, e.berr);
         end
      end
   end
   initial begin
      rst = 1'b1; in_valid = 1'b0; alu_out = 0; store_data = 0; funct3 = 0; rd = 0;
      control_unit_signal = 0;
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = 0;
      step();
      step();
      check("rst_in_ready", in_ready, 1);
      check("rst_o_valid", o_valid, 0);
      check("rst_req_valid", bus.dmem_req_valid, 0);
      check("rst_o_alu_out", o_alu_out, 0);
      check("rst_o_ctl", o_control_unit_signal, 0);
      rst = 1'b0;
      push(32'h0, 32'h1234, 5'd5, 8'h01, 1'b0, 1'b0);
      issue(32'h1234, 32'h0, 3'd0, 5'd5, 8'h01);
      check("add_no_req", bus.dmem_req_valid, 0);
      check("add_in_ready", in_ready, 1);
      check("add_o_valid", o_valid, 1);
      do_load(32'h103, 3'd0, 5'd6, 32'h80FF_FF00, 32'hFFFF_FF80);
      do_load(32'h103, 3'd4, 5'd7, 32'h80FF_FF00, 32'h0000_0080);
      do_load(32'h102, 3'd1, 5'd8, 32'h8001_1234, 32'hFFFF_8001);
      do_load(32'h102, 3'd5, 5'd9, 32'h8001_1234, 32'h0000_8001);
      do_load(32'h104, 3'd2, 5'd10, 32'hCAFE_F00D, 32'hCAFE_F00D);
      do_store(32'h202, 32'h0000_ABCD, 3'd1, 4'b1100, 32'hABCD_ABCD, 3);
      do_store(32'h201, 32'h1234_565A, 3'd0, 4'b0010, 32'h5A5A_5A5A, 0);
      do_store(32'h204, 32'hDEAD_BEEF, 3'd2, 4'b1111, 32'hDEAD_BEEF, 1);
      push(32'h0, 32'h101, 5'd11, 8'h0C, 1'b1, 1'b0);
      issue(32'h101, 32'h0, 3'd2, 5'd11, 8'h0D);
      check("mis_no_req", bus.dmem_req_valid, 0);
      check("mis_in_ready", in_ready, 1);
      push(32'h0, 32'h305, 5'd12, 8'h0C, 1'b1, 1'b0);
      issue(32'h305, 32'h0, 3'd3, 5'd12, 8'h0D);
      check("bad_f3_no_req", bus.dmem_req_valid, 0);
      push(32'h0, 32'h300, 5'd13, 8'h0C, 1'b0, 1'b1);
      issue(32'h300, 32'h0, 3'd2, 5'd13, 8'h0D);
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      nv = n_valid;
      step(); step(); step();
      check("to_no_early_valid", n_valid, nv);
      check("to_in_ready_wait", in_ready, 0);
      step();
      check("to_bus_error", o_bus_error, 1);
      check("to_o_valid", o_valid, 1);
      check("to_in_ready_back", in_ready, 1);
      step();
      nv = n_valid;
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rsp_data  = 32'h1111_2222;
      step();
      bus.dmem_rsp_valid = 1'b0;
      step();
      check("late_rsp_ignored", n_valid, nv);
      issue(32'h400, 32'h0, 3'd2, 5'd14, 8'h0D);
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("rstw_in_ready", in_ready, 1);
      check("rstw_o_valid", o_valid, 0);
      check("rstw_req_valid", bus.dmem_req_valid, 0);
      check("rstw_o_alu_out", o_alu_out, 0);
      check("rstw_o_rd", o_rd, 0);
      check("rstw_o_ctl", o_control_unit_signal, 0);
      check("rstw_o_bus_error", o_bus_error, 0);
      rst = 1'b0;
      push(32'h0, 32'h55AA, 5'd3, 8'h01, 1'b0, 1'b0);
      issue(32'h55AA, 32'h0, 3'd0, 5'd3, 8'h01);
      check("post_rst_add_valid", o_valid, 1);
      step();
      step();
      check("scoreboard_drained", 64'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
